// File: rtl/gpu_pkg.sv
// Shared constants and state encoding for the SIMD instruction fetch stage.
package gpu_pkg;

  localparam int PROGRAM_MEM_ADDR_BITS = 8;
  localparam int INSTR_WIDTH           = 32;
  localparam int NUM_WAVES             = 5;
  localparam int CTX_W                 = $clog2(NUM_WAVES);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQUEST = 2'd1,
    DRAIN   = 2'd2,
    DONE    = 2'd3
  } fetch_state_t;

endpackage

// File: rtl/wave_fetcher_if.sv
// Program-memory read channel and decode-side instruction channel of the fetcher.
interface wave_fetcher_if;
  import gpu_pkg::*;

  logic                             mem_read_valid;
  logic [PROGRAM_MEM_ADDR_BITS-1:0] mem_read_address;
  logic                             mem_read_ready;
  logic [INSTR_WIDTH-1:0]           mem_read_data;

  logic                             instr_valid;
  logic [INSTR_WIDTH-1:0]           instr_out;
  logic [CTX_W-1:0]                 instr_context;
  logic                             instr_ready;

  modport master (
    output mem_read_valid, mem_read_address,
    input  mem_read_ready, mem_read_data,
    output instr_valid, instr_out, instr_context,
    input  instr_ready
  );

  modport slave (
    input  mem_read_valid, mem_read_address,
    output mem_read_ready, mem_read_data,
    input  instr_valid, instr_out, instr_context,
    output instr_ready
  );

endinterface

// File: rtl/fetch_tag_buffer.sv
// One {valid, tag, data} entry per wave context holding the last fetched instruction.
// Invalidation of an entry always beats a fill of the same entry in the same cycle,
// and a pending invalidate also masks the combinational hit.
module fetch_tag_buffer
  import gpu_pkg::*;
(
  input  logic                             clk,
  input  logic                             rst,
  input  logic [CTX_W-1:0]                 rd_ctx,
  input  logic [PROGRAM_MEM_ADDR_BITS-1:0] rd_tag,
  output logic                             rd_hit,
  output logic [INSTR_WIDTH-1:0]           rd_data,
  input  logic                             wr_en,
  input  logic [CTX_W-1:0]                 wr_ctx,
  input  logic [PROGRAM_MEM_ADDR_BITS-1:0] wr_tag,
  input  logic [INSTR_WIDTH-1:0]           wr_data,
  input  logic [NUM_WAVES-1:0]             invalidate
);

  logic [NUM_WAVES-1:0]             valid;
  logic [PROGRAM_MEM_ADDR_BITS-1:0] tag  [NUM_WAVES];
  logic [INSTR_WIDTH-1:0]           data [NUM_WAVES];

  // Valid bits: cleared by reset or invalidate, set by a fill.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= '0;
    end else begin
      for (int k = 0; k < NUM_WAVES; k++) begin
        if (invalidate[k]) begin
          valid[k] <= 1'b0;
        end else if (wr_en && (wr_ctx == CTX_W'(k))) begin
          valid[k] <= 1'b1;
        end
      end
    end
  end

  // Tag/data payload; meaningless while the entry is invalid, so no reset needed.
  always_ff @(posedge clk) begin
    for (int k = 0; k < NUM_WAVES; k++) begin
      if (wr_en && (wr_ctx == CTX_W'(k))) begin
        tag[k]  <= wr_tag;
        data[k] <= wr_data;
      end
    end
  end

  // Combinational lookup; context ids beyond NUM_WAVES-1 never hit.
  always_comb begin
    rd_hit  = 1'b0;
    rd_data = '0;
    for (int k = 0; k < NUM_WAVES; k++) begin
      if (rd_ctx == CTX_W'(k)) begin
        rd_hit  = valid[k] && (tag[k] == rd_tag) && !invalidate[k];
        rd_data = data[k];
      end
    end
  end

endmodule

// File: rtl/wave_fetcher.sv
// Per-SIMD instruction fetch stage: latches PC/context, reads program memory (or the
// per-context last-instruction buffer) and hands the instruction to decode.
module wave_fetcher
  import gpu_pkg::*;
#(
  parameter int PROGRAM_MEM_ADDR_WIDTH = 32
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              fetch_start,
  input  logic [CTX_W-1:0]                  active_context,
  input  logic [PROGRAM_MEM_ADDR_WIDTH-1:0] pc_in,
  input  logic                              flush,
  input  logic [NUM_WAVES-1:0]              wave_reset,
  wave_fetcher_if.master                    bus,
  output logic                              fetch_busy
);

  fetch_state_t state, state_next;

  logic [PROGRAM_MEM_ADDR_BITS-1:0] pc_q;
  logic [CTX_W-1:0]                 ctx_q;
  logic [INSTR_WIDTH-1:0]           instr_q;
  logic [CTX_W-1:0]                 instr_ctx_q;

  logic [PROGRAM_MEM_ADDR_BITS-1:0] pc_tag;
  logic                             start_ok;
  logic                             buf_hit;
  logic [INSTR_WIDTH-1:0]           buf_data;
  logic                             fill_en;
  logic                             unused_pc_hi;

  // Upper PC bits select nothing in the physical program memory.
  assign pc_tag       = pc_in[PROGRAM_MEM_ADDR_BITS-1:0];
  assign unused_pc_hi = ^pc_in[PROGRAM_MEM_ADDR_WIDTH-1:PROGRAM_MEM_ADDR_BITS];

  // A flush in the same cycle cancels the fetch request.
  assign start_ok = fetch_start && !flush;
  // A beat that completes under flush is discarded and must not fill the buffer.
  assign fill_en  = (state == REQUEST) && bus.mem_read_ready && !flush;

  fetch_tag_buffer u_tag_buffer (
    .clk        (clk),
    .rst        (rst),
    .rd_ctx     (active_context),
    .rd_tag     (pc_tag),
    .rd_hit     (buf_hit),
    .rd_data    (buf_data),
    .wr_en      (fill_en),
    .wr_ctx     (ctx_q),
    .wr_tag     (pc_q),
    .wr_data    (bus.mem_read_data),
    .invalidate (wave_reset)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (start_ok) state_next = buf_hit ? DONE : REQUEST;
      end
      REQUEST: begin
        if (bus.mem_read_ready) state_next = flush ? IDLE : DONE;
        else if (flush)         state_next = DRAIN;
      end
      DRAIN: begin
        if (bus.mem_read_ready) state_next = IDLE;
      end
      DONE: begin
        if (flush || bus.instr_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Outputs decoded from the current state.
  always_comb begin
    bus.mem_read_valid = (state == REQUEST) || (state == DRAIN);
    bus.instr_valid    = (state == DONE);
    fetch_busy         = (state != IDLE);
  end

  // Request address/context latch and instruction capture from buffer or memory.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q        <= '0;
      ctx_q       <= '0;
      instr_q     <= '0;
      instr_ctx_q <= '0;
    end else begin
      if ((state == IDLE) && start_ok) begin
        pc_q  <= pc_tag;
        ctx_q <= active_context;
        if (buf_hit) begin
          instr_q     <= buf_data;
          instr_ctx_q <= active_context;
        end
      end
      if (fill_en) begin
        instr_q     <= bus.mem_read_data;
        instr_ctx_q <= ctx_q;
      end
    end
  end

  assign bus.mem_read_address = pc_q;
  assign bus.instr_out        = instr_q;
  assign bus.instr_context    = instr_ctx_q;

endmodule

// File: tb/tb_wave_fetcher.sv
// Directed, table-driven bench for wave_fetcher plus hand-written corner sequences.
module tb_wave_fetcher;
  import gpu_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        fetch_start;
  logic [2:0]  active_context;
  logic [31:0] pc_in;
  logic        flush;
  logic [4:0]  wave_reset;
  logic        fetch_busy;

  int checks   = 0;
  int failures = 0;

  wave_fetcher_if bus ();

  wave_fetcher #(.PROGRAM_MEM_ADDR_WIDTH(32)) dut (
    .clk            (clk),
    .rst            (rst),
    .fetch_start    (fetch_start),
    .active_context (active_context),
    .pc_in          (pc_in),
    .flush          (flush),
    .wave_reset     (wave_reset),
    .bus            (bus),
    .fetch_busy     (fetch_busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  ctx;
    logic [31:0] pc;
    int          lat;
    logic [31:0] mdata;
    logic [4:0]  wr_start;
    logic [4:0]  wr_fill;
    bit          hit;
    logic [31:0] exp_instr;
  } vec_t;

  vec_t vecs [15];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    fetch_start         = 1'b0;
    flush               = 1'b0;
    wave_reset          = '0;
    bus.mem_read_ready  = 1'b0;
    bus.mem_read_data   = '0;
    bus.instr_ready     = 1'b0;
  endtask

  // Full fetch: start, optional memory wait, delivery, decode handshake.
  task automatic run_fetch(input vec_t v, input string tag);
    fetch_start    = 1'b1;
    active_context = v.ctx;
    pc_in          = v.pc;
    wave_reset     = v.wr_start;
    tick();
    fetch_start = 1'b0;
    wave_reset  = '0;
    if (v.hit) begin
      chk({tag, " hit mem_read_valid"}, {31'b0, bus.mem_read_valid}, 32'd0);
    end else begin
      chk({tag, " miss mem_read_valid"}, {31'b0, bus.mem_read_valid}, 32'd1);
      chk({tag, " miss address"}, {24'b0, bus.mem_read_address}, {24'b0, v.pc[7:0]});
      chk({tag, " miss early instr_valid"}, {31'b0, bus.instr_valid}, 32'd0);
      for (int i = 0; i < v.lat; i++) begin
        tick();
        chk({tag, " wait address"}, {24'b0, bus.mem_read_address}, {24'b0, v.pc[7:0]});
      end
      bus.mem_read_ready = 1'b1;
      bus.mem_read_data  = v.mdata;
      wave_reset         = v.wr_fill;
      tick();
      bus.mem_read_ready = 1'b0;
      bus.mem_read_data  = '0;
      wave_reset         = '0;
      chk({tag, " mem_read_valid drop"}, {31'b0, bus.mem_read_valid}, 32'd0);
    end
    chk({tag, " instr_valid"}, {31'b0, bus.instr_valid}, 32'd1);
    chk({tag, " instr_out"}, bus.instr_out, v.exp_instr);
    chk({tag, " instr_context"}, {29'b0, bus.instr_context}, {29'b0, v.ctx});
    bus.instr_ready = 1'b1;
    tick();
    bus.instr_ready = 1'b0;
    chk({tag, " back to idle"}, {31'b0, fetch_busy}, 32'd0);
  endtask

  logic [31:0] held;

  initial begin
    vecs[0]  = '{3'd2, 32'h0000_0014, 3, 32'hDEAD_BEEF, 5'b0,     5'b0,     1'b0, 32'hDEAD_BEEF};
    vecs[1]  = '{3'd2, 32'h0000_0014, 0, 32'h0,         5'b0,     5'b0,     1'b1, 32'hDEAD_BEEF};
    vecs[2]  = '{3'd2, 32'h0000_0114, 0, 32'h0,         5'b0,     5'b0,     1'b1, 32'hDEAD_BEEF};
    vecs[3]  = '{3'd2, 32'h0000_0114, 2, 32'hCAFE_0001, 5'b00100, 5'b0,     1'b0, 32'hCAFE_0001};
    vecs[4]  = '{3'd2, 32'h0000_0014, 0, 32'h0,         5'b0,     5'b0,     1'b1, 32'hCAFE_0001};
    vecs[5]  = '{3'd0, 32'h0000_0020, 0, 32'h1111_0000, 5'b0,     5'b0,     1'b0, 32'h1111_0000};
    vecs[6]  = '{3'd4, 32'h0000_00FF, 1, 32'hA5A5_5A5A, 5'b0,     5'b0,     1'b0, 32'hA5A5_5A5A};
    vecs[7]  = '{3'd0, 32'h0000_0020, 0, 32'h0,         5'b0,     5'b0,     1'b1, 32'h1111_0000};
    vecs[8]  = '{3'd0, 32'h0000_0024, 0, 32'h2222_0000, 5'b0,     5'b0,     1'b0, 32'h2222_0000};
    vecs[9]  = '{3'd0, 32'h0000_0020, 0, 32'h3333_0000, 5'b0,     5'b0,     1'b0, 32'h3333_0000};
    vecs[10] = '{3'd4, 32'hABCD_00FF, 0, 32'h0,         5'b00001, 5'b0,     1'b1, 32'hA5A5_5A5A};
    vecs[11] = '{3'd3, 32'h0000_0040, 1, 32'h0BAD_F00D, 5'b0,     5'b01000, 1'b0, 32'h0BAD_F00D};
    vecs[12] = '{3'd3, 32'h0000_0040, 0, 32'h0BAD_F00E, 5'b0,     5'b0,     1'b0, 32'h0BAD_F00E};
    vecs[13] = '{3'd3, 32'h0000_0040, 0, 32'h0,         5'b0,     5'b0,     1'b1, 32'h0BAD_F00E};
    vecs[14] = '{3'd2, 32'h0000_0014, 0, 32'h0,         5'b0,     5'b0,     1'b1, 32'hCAFE_0001};

    idle_inputs();
    active_context = '0;
    pc_in          = '0;
    rst            = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    chk("reset busy", {31'b0, fetch_busy}, 32'd0);
    chk("reset mem_read_valid", {31'b0, bus.mem_read_valid}, 32'd0);
    chk("reset instr_valid", {31'b0, bus.instr_valid}, 32'd0);

    for (int i = 0; i < 15; i++) begin
      run_fetch(vecs[i], $sformatf("vec%0d", i));
    end

    // Reset while a request is outstanding.
    fetch_start    = 1'b1;
    active_context = 3'd1;
    pc_in          = 32'h0000_0030;
    tick();
    fetch_start = 1'b0;
    chk("rst-mid mem_read_valid before", {31'b0, bus.mem_read_valid}, 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst-mid mem_read_valid", {31'b0, bus.mem_read_valid}, 32'd0);
    chk("rst-mid address", {24'b0, bus.mem_read_address}, 32'd0);
    chk("rst-mid instr_valid", {31'b0, bus.instr_valid}, 32'd0);
    chk("rst-mid instr_out", bus.instr_out, 32'd0);
    chk("rst-mid instr_context", {29'b0, bus.instr_context}, 32'd0);
    chk("rst-mid busy", {31'b0, fetch_busy}, 32'd0);
    run_fetch('{3'd4, 32'h0000_00FF, 0, 32'h5555_00FF, 5'b0, 5'b0, 1'b0, 32'h5555_00FF}, "post-rst");

    // Flush in REQUEST with memory stalled: DRAIN keeps the request up.
    fetch_start    = 1'b1;
    active_context = 3'd1;
    pc_in          = 32'h0000_0050;
    tick();
    fetch_start = 1'b0;
    flush       = 1'b1;
    tick();
    flush = 1'b0;
    chk("drain mem_read_valid 1", {31'b0, bus.mem_read_valid}, 32'd1);
    chk("drain address", {24'b0, bus.mem_read_address}, 32'h50);
    chk("drain instr_valid 1", {31'b0, bus.instr_valid}, 32'd0);
    tick();
    chk("drain mem_read_valid 2", {31'b0, bus.mem_read_valid}, 32'd1);
    bus.mem_read_ready = 1'b1;
    bus.mem_read_data  = 32'h7777_7777;
    tick();
    bus.mem_read_ready = 1'b0;
    chk("drain done mem_read_valid", {31'b0, bus.mem_read_valid}, 32'd0);
    chk("drain done busy", {31'b0, fetch_busy}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("drain no instr_valid", {31'b0, bus.instr_valid}, 32'd0);
    end
    run_fetch('{3'd1, 32'h0000_0050, 0, 32'h7777_0050, 5'b0, 5'b0, 1'b0, 32'h7777_0050}, "post-drain");

    // Flush coinciding with the memory beat: discarded, nothing cached.
    fetch_start    = 1'b1;
    active_context = 3'd1;
    pc_in          = 32'h0000_0060;
    tick();
    fetch_start        = 1'b0;
    flush              = 1'b1;
    bus.mem_read_ready = 1'b1;
    bus.mem_read_data  = 32'h6666_6666;
    tick();
    flush              = 1'b0;
    bus.mem_read_ready = 1'b0;
    chk("flush+ready busy", {31'b0, fetch_busy}, 32'd0);
    chk("flush+ready instr_valid", {31'b0, bus.instr_valid}, 32'd0);
    run_fetch('{3'd1, 32'h0000_0060, 1, 32'h6666_0060, 5'b0, 5'b0, 1'b0, 32'h6666_0060}, "post-flush-beat");

    // DONE stalled by decode; fetch_start must be ignored; then flush with instr_ready.
    fetch_start    = 1'b1;
    active_context = 3'd0;
    pc_in          = 32'h0000_0070;
    tick();
    fetch_start        = 1'b0;
    bus.mem_read_ready = 1'b1;
    bus.mem_read_data  = 32'h9999_0070;
    tick();
    bus.mem_read_ready = 1'b0;
    held = bus.instr_out;
    chk("stall first instr_out", held, 32'h9999_0070);
    fetch_start    = 1'b1;
    active_context = 3'd4;
    pc_in          = 32'h0000_00FF;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("stall instr_valid", {31'b0, bus.instr_valid}, 32'd1);
      chk("stall instr_out", bus.instr_out, 32'h9999_0070);
      chk("stall instr_context", {29'b0, bus.instr_context}, 32'd0);
      chk("stall mem_read_valid", {31'b0, bus.mem_read_valid}, 32'd0);
    end
    fetch_start     = 1'b0;
    flush           = 1'b1;
    bus.instr_ready = 1'b1;
    tick();
    flush           = 1'b0;
    bus.instr_ready = 1'b0;
    chk("flush-done instr_valid", {31'b0, bus.instr_valid}, 32'd0);
    chk("flush-done busy", {31'b0, fetch_busy}, 32'd0);

    // Flush together with fetch_start in IDLE: nothing starts.
    fetch_start    = 1'b1;
    flush          = 1'b1;
    active_context = 3'd0;
    pc_in          = 32'h0000_0070;
    tick();
    fetch_start = 1'b0;
    flush       = 1'b0;
    chk("flush-start busy", {31'b0, fetch_busy}, 32'd0);
    chk("flush-start instr_valid", {31'b0, bus.instr_valid}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
